// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// registers the returned word into the instruction register feeding the decoder.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  stall,
  input  logic                  jmp_flag,
  input  logic [31:0]           jmp_address,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_offset,
  output logic [31:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  instr_valid
);

  typedef enum logic [1:0] {S_START, S_RUN, S_FLUSH, S_STALL} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next;
  logic [ADDR_WIDTH-1:0] pc_out_next;
  logic [31:0]           instr_out_next;
  logic                  instr_valid_next;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] branch_ext;
  logic [ADDR_WIDTH-1:0] target;

  assign imem_addr  = pc;
  assign redirect   = instr_valid & ~stall & (jmp_flag | branch_taken);
  assign branch_ext = ADDR_WIDTH'($signed(branch_offset));
  assign target     = jmp_flag ? jmp_address[ADDR_WIDTH-1:0]
                               : pc_out + ADDR_WIDTH'(1) + branch_ext;

  always_ff @(posedge clk) begin
    if (rst) state <= S_START;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_START: state_next = S_RUN;
      S_RUN:   if (stall) state_next = S_STALL;
               else if (redirect) state_next = S_FLUSH;
      S_FLUSH: state_next = S_RUN;
      S_STALL: if (!stall) state_next = redirect ? S_FLUSH : S_RUN;
      default: state_next = S_START;
    endcase
  end

  // A stall rewinds pc to fetch_pc because the word in flight from memory is
  // dropped while stalled and must be fetched again on release.
  always_comb begin
    pc_next          = pc;
    fetch_pc_next    = fetch_pc;
    pc_out_next      = pc_out;
    instr_out_next   = instr_out;
    instr_valid_next = instr_valid;
    case (state)
      S_START, S_FLUSH: begin
        fetch_pc_next    = pc;
        pc_next          = pc + ADDR_WIDTH'(1);
        instr_out_next   = NOP_WORD;
        instr_valid_next = 1'b0;
      end
      S_RUN: begin
        if (stall) begin
          pc_next = fetch_pc;
        end else if (redirect) begin
          pc_next          = target;
          instr_out_next   = NOP_WORD;
          instr_valid_next = 1'b0;
        end else begin
          instr_out_next   = imem_rdata;
          pc_out_next      = fetch_pc;
          instr_valid_next = 1'b1;
          fetch_pc_next    = pc;
          pc_next          = pc + ADDR_WIDTH'(1);
        end
      end
      S_STALL: begin
        if (!stall) begin
          instr_out_next   = NOP_WORD;
          instr_valid_next = 1'b0;
          if (redirect) begin
            pc_next = target;
          end else begin
            fetch_pc_next = pc;
            pc_next       = pc + ADDR_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_pc    <= RESET_PC;
      pc_out      <= '0;
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
    end else begin
      pc          <= pc_next;
      fetch_pc    <= fetch_pc_next;
      pc_out      <= pc_out_next;
      instr_out   <= instr_out_next;
      instr_valid <= instr_valid_next;
    end
  end

endmodule
